// File: rtl/spi_regfile_peripheral_pkg.sv
// spi_pkg: shared definitions for the SPI register-file peripheral.
//   - spi_state_e : frame state (IDLE between frames, ACTIVE while nCS is low)
//   - RW_WRITE / RW_READ : encoding of the first bit of a frame
//   - frame-field helpers : frame length and bit positions of the R/W,
//     address and data fields in a fully received frame (bit 0 = last bit in)
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // R/W bit + address + data.
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Number of bits up to and including the address (read data is looked up here).
  function automatic int hdr_len(input int addr_w);
    return 1 + addr_w;
  endfunction

  // Position of the R/W bit once the whole frame has been shifted in.
  function automatic int rw_pos(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  // Position of the address LSB once the whole frame has been shifted in.
  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_peripheral_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with edge detection.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_d        : asynchronous input
//   o_level    : synchronised level (the newer of the two edge-detect stages)
//   o_rise     : one-clk pulse on a synchronised rising edge
//   o_fall     : one-clk pulse on a synchronised falling edge
// Every stage resets to RESET_VAL so an input sitting at its idle level
// produces no spurious edge when reset is released.
module spi_sync_edge #(
  parameter int SYNC_FLOPS = 2,
  parameter bit RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  // r_sync[0] is the first stage, r_sync[SYNC_FLOPS-1] the last.
  logic [SYNC_FLOPS-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_FLOPS{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_FLOPS-2:0], i_d};
    end
  end

  // Edges are taken between the last two stages; the level is reported from
  // the newer of them so it is aligned with the edge pulses.
  assign o_level = r_sync[SYNC_FLOPS-2];
  assign o_rise  =  r_sync[SYNC_FLOPS-2] & ~r_sync[SYNC_FLOPS-1];
  assign o_fall  = ~r_sync[SYNC_FLOPS-2] &  r_sync[SYNC_FLOPS-1];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral: SPI target giving an external controller read/write
// access to NUM_REGS registers of DATA_W bits.
// Frame (MSB first): R/W (1 = write), ADDR_W address bits, DATA_W data bits.
// Ports:
//   clk, rst_n : system clock (>= 8x SCLK), asynchronous active-low reset
//   SCLK, COPI, nCS : SPI pins from the controller (asynchronous to clk)
//   CIPO, cipo_oe   : read data to the controller and its pad enable
//   regs_o    : flat register bus, reg k at [k*DATA_W +: DATA_W]
//   wr_pulse  : one-clk pulse when a write commits
//   wr_addr   : address of the last committed write
//   frame_err : one-clk pulse when nCS rises on a frame of the wrong length
module spi_regfile_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_FLOPS = 2,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 5,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int HDR_LEN   = hdr_len(ADDR_W);
  localparam int RW_POS    = rw_pos(ADDR_W, DATA_W);
  localparam int ADDR_LSB  = addr_lsb(DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_HDR    = CNT_W'(HDR_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(FRAME_LEN + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);
  localparam bit SAMPLE_RISE = ((CPOL ^ CPHA) == 1'b0);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_ncs_lvl, w_ncs_rise, w_ncs_fall;
  logic w_copi, w_copi_rise, w_copi_fall;

  spi_sync_edge #(.SYNC_FLOPS(SYNC_FLOPS), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(SCLK),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.SYNC_FLOPS(SYNC_FLOPS), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .i_d(nCS),
    .o_level(w_ncs_lvl), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );
  spi_sync_edge #(.SYNC_FLOPS(SYNC_FLOPS), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .i_d(COPI),
    .o_level(w_copi), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
  );

  // Only the edge pulses of SCLK/nCS and the level of COPI are needed.
  logic w_unused;
  assign w_unused = ^{w_sclk_lvl, w_ncs_lvl, w_copi_rise, w_copi_fall};

  spi_state_e r_state, w_state_next;

  logic [CNT_W-1:0]     r_cnt;
  logic [FRAME_LEN-1:0] r_shift;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_rd_armed;
  logic                 r_cipo, r_cipo_oe, r_wr_pulse, r_frame_err;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [DATA_W-1:0]    r_regs [NUM_REGS];

  // SCLK edges count only inside a frame and never on a cycle where nCS moves.
  logic w_sclk_ok, w_sample, w_shift_edge;
  assign w_sclk_ok    = (r_state == ST_ACTIVE) && !w_ncs_rise && !w_ncs_fall;
  assign w_sample     = w_sclk_ok && (SAMPLE_RISE ? w_sclk_rise : w_sclk_fall);
  assign w_shift_edge = w_sclk_ok && (SAMPLE_RISE ? w_sclk_fall : w_sclk_rise);

  logic [FRAME_LEN-1:0] w_shift_next;
  logic [CNT_W-1:0]     w_cnt_inc;
  assign w_shift_next = {r_shift[FRAME_LEN-2:0], w_copi};
  assign w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // Header view (valid when the address has just completed) and full-frame view.
  logic              w_hdr_rw, w_frm_rw, w_hdr_valid, w_frm_valid;
  logic [ADDR_W-1:0] w_hdr_addr, w_frm_addr;
  logic [DATA_W-1:0] w_frm_data, w_rd_lookup;
  assign w_hdr_rw    = w_shift_next[ADDR_W];
  assign w_hdr_addr  = w_shift_next[ADDR_W-1:0];
  assign w_frm_rw    = r_shift[RW_POS];
  assign w_frm_addr  = r_shift[ADDR_LSB +: ADDR_W];
  assign w_frm_data  = r_shift[DATA_W-1:0];
  assign w_hdr_valid = {1'b0, w_hdr_addr} < NUM_REGS_X;
  assign w_frm_valid = {1'b0, w_frm_addr} < NUM_REGS_X;

  always_comb begin
    w_rd_lookup = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_hdr_valid && (w_hdr_addr == ADDR_W'(k))) w_rd_lookup = r_regs[k];
    end
  end

  logic w_commit;
  assign w_commit = w_ncs_rise && (r_state == ST_ACTIVE) && (r_cnt == CNT_FULL)
                    && (w_frm_rw == RW_WRITE) && w_frm_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_ncs_fall) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_ncs_rise) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rdata     <= '0;
      r_rd_armed  <= 1'b0;
      r_cipo      <= 1'b0;
      r_cipo_oe   <= 1'b0;
      r_wr_pulse  <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= '0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else begin
      r_wr_pulse  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_ncs_fall) begin
        r_cnt      <= '0;
        r_shift    <= '0;
        r_rd_armed <= 1'b0;
        r_cipo     <= 1'b0;
        r_cipo_oe  <= 1'b0;
      end else if (w_ncs_rise) begin
        if (r_state == ST_ACTIVE) begin
          if (r_cnt != CNT_FULL) begin
            r_frame_err <= 1'b1;
          end else if (w_commit) begin
            r_wr_pulse <= 1'b1;
            r_wr_addr  <= w_frm_addr;
          end
        end
        for (int k = 0; k < NUM_REGS; k++) begin
          if (w_commit && (w_frm_addr == ADDR_W'(k))) r_regs[k] <= w_frm_data;
        end
        r_rd_armed <= 1'b0;
        r_cipo     <= 1'b0;
        r_cipo_oe  <= 1'b0;
      end else begin
        if (w_sample) begin
          r_shift <= w_shift_next;
          r_cnt   <= w_cnt_inc;
          // Read data is captured the moment the last address bit arrives.
          if ((w_cnt_inc == CNT_HDR) && (r_cnt != CNT_HDR) && (w_hdr_rw == RW_READ)) begin
            r_rdata    <= w_rd_lookup;
            r_rd_armed <= 1'b1;
          end
        end
        // Zero-fill shifting leaves CIPO at 0 once the LSB has gone out.
        if (w_shift_edge && r_rd_armed) begin
          r_cipo_oe <= 1'b1;
          r_cipo    <= r_rdata[DATA_W-1];
          r_rdata   <= {r_rdata[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_flat
    assign regs_o[gi*DATA_W +: DATA_W] = r_regs[gi];
  end

  assign CIPO      = r_cipo;
  assign cipo_oe   = r_cipo_oe;
  assign wr_pulse  = r_wr_pulse;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench for spi_regfile_peripheral.
// Two instances: u_dut0 (defaults, mode 0) and u_dut1 (CPOL=1, CPHA=1,
// DATA_W=16, NUM_REGS=8). A bit-banged SPI controller drives each; a
// register-array model tracks the expected register contents.
module tb_spi_regfile_peripheral;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] sclk = 2'b10;   // idle levels: inst0 CPOL=0, inst1 CPOL=1
  logic [1:0] copi = 2'b00;
  logic [1:0] ncs  = 2'b11;

  logic cipo0, cipo1, oe0, oe1, wrp0, wrp1, ferr0, ferr1;
  logic [39:0]  regs0;
  logic [127:0] regs1;
  logic [6:0]   wra0, wra1;

  int errors = 0;
  int checks = 0;
  int wr_cnt [2];
  int err_cnt [2];
  logic [15:0] model [2][8];
  logic [6:0]  last_addr [2];

  always #5 clk = ~clk;

  spi_regfile_peripheral #(.SYNC_FLOPS(2), .ADDR_W(7), .DATA_W(8), .NUM_REGS(5),
                           .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk[0]), .COPI(copi[0]), .nCS(ncs[0]),
    .CIPO(cipo0), .cipo_oe(oe0), .regs_o(regs0), .wr_pulse(wrp0),
    .wr_addr(wra0), .frame_err(ferr0)
  );

  spi_regfile_peripheral #(.SYNC_FLOPS(2), .ADDR_W(7), .DATA_W(16), .NUM_REGS(8),
                           .CPOL(1'b1), .CPHA(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk[1]), .COPI(copi[1]), .nCS(ncs[1]),
    .CIPO(cipo1), .cipo_oe(oe1), .regs_o(regs1), .wr_pulse(wrp1),
    .wr_addr(wra1), .frame_err(ferr1)
  );

  initial begin
    wr_cnt[0] = 0; wr_cnt[1] = 0; err_cnt[0] = 0; err_cnt[1] = 0;
  end

  // Pulse counters, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (wrp0)  wr_cnt[0]  = wr_cnt[0] + 1;
    if (wrp1)  wr_cnt[1]  = wr_cnt[1] + 1;
    if (ferr0) err_cnt[0] = err_cnt[0] + 1;
    if (ferr1) err_cnt[1] = err_cnt[1] + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  function automatic logic [127:0] model_flat(input int inst);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      if (inst == 0) begin
        if (k < 5) v[k*8 +: 8] = model[0][k][7:0];
      end else begin
        v[k*16 +: 16] = model[1][k];
      end
    end
    return v;
  endfunction

  function automatic logic [127:0] dut_regs(input int inst);
    return (inst == 0) ? {88'd0, regs0} : regs1;
  endfunction

  function automatic logic dut_cipo(input int inst);
    return (inst == 0) ? cipo0 : cipo1;
  endfunction

  function automatic logic dut_oe(input int inst);
    return (inst == 0) ? oe0 : oe1;
  endfunction

  // Controller side of one frame. Bits beyond the real frame length L are 0.
  // CIPO is captured just before each sample edge; oe is expected high from
  // the first data bit on for reads.
  task automatic xfer(input int inst, input int nbits, input logic [31:0] f, input int L,
                      input bit raise, input bit rd, output logic [15:0] rx, output bit oe_bad);
    logic b;
    rx = '0;
    oe_bad = 1'b0;
    ncs[inst] = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      b = (i < L) ? f[L-1-i] : 1'b0;
      if (inst == 0) begin
        copi[0] = b;
        half();
      end else begin
        sclk[1] = 1'b0;
        copi[1] = b;
        half();
      end
      if (rd && i >= 8 && i < L) rx = {rx[14:0], dut_cipo(inst)};
      if (dut_oe(inst) !== (rd && i >= 8)) oe_bad = 1'b1;
      sclk[inst] = 1'b1;
      half();
      if (inst == 0) sclk[0] = 1'b0;
    end
    half();
    if (raise) begin
      ncs[inst] = 1'b1;
      copi[inst] = 1'b0;
      half();
      half();
    end
  endtask

  task automatic do_frame(input int inst, input int nbits, input logic rw,
                          input logic [6:0] addr, input logic [15:0] data);
    int dw, nr, L, wr0, er0;
    logic [31:0] f;
    logic [15:0] rx, exp_rd;
    bit oe_bad, hit, full, commit;
    string tag;
    dw = (inst == 0) ? 8 : 16;
    nr = (inst == 0) ? 5 : 8;
    L  = 8 + dw;
    if (inst == 0) f = {16'd0, rw, addr, data[7:0]};
    else           f = {8'd0, rw, addr, data};
    hit    = (int'(addr) < nr);
    full   = (nbits == L);
    commit = full && rw && hit;
    exp_rd = hit ? model[inst][addr[2:0]] : 16'd0;
    wr0 = wr_cnt[inst];
    er0 = err_cnt[inst];
    xfer(inst, nbits, f, L, 1'b1, !rw, rx, oe_bad);
    if (commit) begin
      model[inst][addr[2:0]] = (inst == 0) ? {8'd0, data[7:0]} : data;
      last_addr[inst] = addr;
    end
    tag = $sformatf("i%0d %s a=%02h d=%04h n=%0d", inst, rw ? "wr" : "rd", addr, data, nbits);
    check({tag, " wr_pulse"}, 128'(wr_cnt[inst] - wr0), commit ? 128'd1 : 128'd0);
    check({tag, " frame_err"}, 128'(err_cnt[inst] - er0), full ? 128'd0 : 128'd1);
    check({tag, " regs"}, dut_regs(inst), model_flat(inst));
    check({tag, " wr_addr"}, 128'((inst == 0) ? wra0 : wra1), 128'(last_addr[inst]));
    check({tag, " idle_cipo_oe"}, {126'd0, dut_oe(inst), dut_cipo(inst)}, 128'd0);
    if (!rw && full) begin
      check({tag, " rdata"}, 128'(rx), 128'(exp_rd));
      check({tag, " oe_timing"}, 128'(oe_bad), 128'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " regs0"}, 128'(regs0), 128'd0);
    check({tag, " regs1"}, regs1, 128'd0);
    check({tag, " pins"}, {120'd0, cipo0, cipo1, oe0, oe1, wrp0, wrp1, ferr0, ferr1}, 128'd0);
    check({tag, " wr_addr"}, {114'd0, wra0, wra1}, 128'd0);
  endtask

  initial begin
    logic [15:0] rx_d;
    bit oe_d;
    int nr, nb, sel, L;
    for (int i = 0; i < 2; i++) begin
      last_addr[i] = '0;
      for (int k = 0; k < 8; k++) model[i][k] = '0;
    end

    // Reset state, during and just after reset.
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_all_zero("after_reset");

    // Mode 0 write then read back.
    do_frame(0, 16, 1'b1, 7'h02, 16'h00A5);
    check("reg2_slice", 128'(regs0[23:16]), 128'h0A5);
    do_frame(0, 16, 1'b0, 7'h02, 16'h0000);

    // Short and overlong writes.
    do_frame(0, 15, 1'b1, 7'h01, 16'h00FF);
    do_frame(0, 17, 1'b1, 7'h01, 16'h00FF);

    // Out-of-range write and read.
    do_frame(0, 16, 1'b1, 7'h10, 16'h003C);
    do_frame(0, 16, 1'b0, 7'h10, 16'h0000);

    // Mode 3, 16-bit data.
    do_frame(1, 24, 1'b1, 7'h07, 16'hBEEF);
    check("reg7_slice", 128'(regs1[127:112]), 128'hBEEF);
    do_frame(1, 24, 1'b0, 7'h07, 16'h0000);

    // Randomised traffic on both instances.
    for (int t = 0; t < 40; t++) begin
      int inst;
      logic [6:0] a;
      inst = t % 2;
      nr = (inst == 0) ? 5 : 8;
      L  = (inst == 0) ? 16 : 24;
      sel = $urandom_range(0, 9);
      a = (sel == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, nr + 1));
      sel = $urandom_range(0, 9);
      nb = (sel == 0) ? L - 1 - $urandom_range(0, 2) : (sel == 1) ? L + 1 : L;
      do_frame(inst, nb, 1'($urandom_range(0, 1)), a, 16'($urandom));
    end

    // Reset in the middle of a write frame.
    xfer(0, 10, {16'd0, 1'b1, 7'h03, 8'h77}, 16, 1'b0, 1'b0, rx_d, oe_d);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("mid_frame_reset");
    ncs[0] = 1'b1;
    copi[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      last_addr[i] = '0;
      for (int k = 0; k < 8; k++) model[i][k] = '0;
    end
    repeat (6) @(negedge clk);
    check_all_zero("after_mid_reset");
    do_frame(0, 16, 1'b1, 7'h00, 16'h0011);
    check("reg0_slice", 128'(regs0[7:0]), 128'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_regfile_peripheral.md
Name: spi_regfile_peripheral

Overview:
Parametrised SPI peripheral giving an external controller read and write access to a bank of NUM_REGS configuration registers, each DATA_W bits wide.
- Frame: R/W bit, ADDR_W-bit address, DATA_W-bit data, all MSB first.
- SPI mode is selectable with CPOL/CPHA.
- Writes commit only on a correctly framed nCS deassertion; reads return register contents on CIPO.
- Sits between the chip pins and the PWM/output-enable logic, which consumes the flat regs_o bus.

Parameters:
SYNC_FLOPS, 2, synchroniser depth for SCLK/COPI/nCS (≥2)
ADDR_W, 7, address field width
DATA_W, 8, register/data field width
NUM_REGS, 5, number of implemented registers (≤ 2**ADDR_W)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge

Ports:
clk  input  1  system clock; must be ≥ 8× SCLK frequency
rst_n  input  1  asynchronous, active-low reset
SCLK  input  1  SPI clock from controller (asynchronous to clk)
COPI  input  1  controller-out data
nCS  input  1  active-low chip select
CIPO  output  1  controller-in data
cipo_oe  output  1  CIPO output enable (pad tristate control)
regs_o  output  NUM_REGS*DATA_W  register contents; reg k at [k*DATA_W +: DATA_W]
wr_pulse  output  1  one-clk pulse when a write commits
wr_addr  output  ADDR_W  address of the last committed write
frame_err  output  1  one-clk pulse on a malformed frame

Behaviour:
- Reset values: regs_o = 0, CIPO = 0, cipo_oe = 0, wr_pulse = 0, wr_addr = 0, frame_err = 0, bit counter = 0, shift register = 0.
  - nCS synchroniser resets to all-1.
  - SCLK synchroniser resets to all-CPOL.
- Synchronisation:
  - Each input passes through SYNC_FLOPS flops; edges are detected on the last two stages.
  - Sample edge: rising if CPOL^CPHA = 0, else falling. Shift edge is the opposite edge.
- Frame: FRAME_LEN = 1 + ADDR_W + DATA_W.
  - Bit 0 is R/W (1 = write), followed by the address, then the data.
- nCS falling edge: clear bit counter and shift register; set state ACTIVE.
- While ACTIVE, on each sample edge:
  - Shift the synchronised COPI into the LSB of the shift register.
  - Increment the bit counter, saturating at FRAME_LEN+1.
- Read path:
  - When the counter reaches 1+ADDR_W with R/W = 0, latch rdata = reg[addr]. If addr ≥ NUM_REGS, rdata = 0.
  - cipo_oe = 1 from the next shift edge until nCS rises.
  - On each shift edge, CIPO presents the next rdata bit, MSB first. After the LSB, CIPO holds 0.
  - CIPO is updated within SYNC_FLOPS+1 clk cycles of the SCLK edge.
- nCS rising edge (state returns to IDLE):
  - Count == FRAME_LEN, R/W = 1, addr < NUM_REGS: write data to reg[addr], set wr_addr, pulse wr_pulse in the same clk cycle.
  - Count == FRAME_LEN, R/W = 1, addr ≥ NUM_REGS: no register change, no wr_pulse, no frame_err.
  - Count == FRAME_LEN, R/W = 0: no register change, no error.
  - Count ≠ FRAME_LEN (short or overlong): frame_err pulse, no register change, no wr_pulse.
  - cipo_oe and CIPO return to 0 on the same cycle.
- Simultaneous events:
  - An SCLK edge detected in the same cycle as the nCS rising edge is ignored.
  - An SCLK edge detected in the same cycle as the nCS falling edge is ignored.
  - SCLK edges while IDLE are ignored.
- nCS low at reset release: the synchroniser sees a falling edge, and a frame starts normally.
- Reset mid-frame: frame aborted, all registers return to 0, no commit.
- Back-to-back frames with a minimum nCS-high time of SYNC_FLOPS+2 clk cycles must both be processed.

Decomposition:
- Package spi_pkg holds:
  - frame-field offset helper functions;
  - the IDLE/ACTIVE state enum;
  - the R/W encoding constants (WRITE = 1, READ = 0).
- Sub-module spi_sync_edge (parameter SYNC_FLOPS, RESET_VAL):
  - synchroniser plus rise/fall pulse outputs;
  - instantiated for SCLK, nCS and COPI (edge outputs unused for COPI).

Test Plan:
- Default params, mode 0: write frame R/W=1, addr 0x02, data 0xA5 → regs_o[23:16] = 0xA5; wr_pulse once; wr_addr = 2; other registers 0.
- After the write, read frame addr 0x02 → CIPO shifts 1010_0101 on the data-phase shift edges; cipo_oe high from the first data shift edge until nCS rises; registers unchanged.
- Write with 15 bits, then a second write with 17 bits (addr 0x01, data 0xFF) → frame_err pulses twice; reg 1 stays 0x00; no wr_pulse.
- Write addr 0x10 (≥ NUM_REGS) with data 0x3C → no register change, no wr_pulse, no frame_err; read of addr 0x10 returns 0x00.
- CPOL=1, CPHA=1, DATA_W=16, NUM_REGS=8: write addr 7, data 0xBEEF, then read back → regs_o[127:112] = 0xBEEF; CIPO returns 0xBEEF.
- rst_n asserted after 10 bits of a write frame → all outputs 0; following full write of addr 0, data 0x11 → reg 0 = 0x11.
